// File: rtl/obuf_uart_tx_if.sv
// Single-byte read port between obuf_uart_tx (master) and the mb8 memory arbiter (slave).
// Handshake: mem_req stays high with a stable mem_addr until a cycle where mem_gnt is also high;
// that cycle transfers the address, and mem_data is valid exactly one cycle later. mem_gnt is
// ignored whenever mem_req is low.
interface obuf_uart_tx_if #(
  parameter int unsigned ASZ = 17
);
  logic           mem_req;
  logic           mem_gnt;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_data;

  modport master (output mem_req, output mem_addr, input mem_gnt, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_gnt, output mem_data);
endinterface

// File: rtl/obuf_uart_tx.sv
// Drains bytes from the OBUF window of byte memory and sends them as 8N1 UART frames, LSB first.
// state_dbg exposes the FSM encoding: 0 IDLE, 1 FETCH, 2 WAIT, 3 START, 4 DATA, 5 STOP, 6 DONE.
module obuf_uart_tx #(
  parameter int unsigned    ASZ          = 17,
  parameter logic [ASZ-1:0] OBUF         = 'h1400,
  parameter logic [ASZ-1:0] OBUF_SZ      = 'h400,
  parameter int unsigned    CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [ASZ-1:0]       len,
  input  logic [ASZ-1:0]       offset,
  input  logic                 abort,
  obuf_uart_tx_if.master       mem,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [ASZ-1:0]       sent,
  output logic [2:0]           state_dbg
);

  localparam int unsigned    BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [ASZ-1:0] MASK      = OBUF_SZ - ASZ'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t         state, state_n;
  logic [BW-1:0]  baud, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic [ASZ-1:0] len_q, len_n;
  logic [ASZ-1:0] off_q, off_n;
  logic [ASZ-1:0] sent_n;
  logic [ASZ-1:0] sent_inc;
  logic           tx_n;
  logic           baud_end;

  assign sent_inc = sent + ASZ'(1);
  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      len_q   <= '0;
      off_q   <= '0;
      sent    <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      len_q   <= len_n;
      off_q   <= off_n;
      sent    <= sent_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    len_n   = len_q;
    off_n   = off_q;
    sent_n  = sent;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          len_n   = (len > OBUF_SZ) ? OBUF_SZ : len;
          off_n   = offset & MASK;
          sent_n  = '0;
          baud_n  = '0;
          bit_n   = '0;
          state_n = (len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        // A grant in the same cycle as abort has already committed the read, so the char goes out.
        if (mem.mem_gnt) state_n = S_WAIT;
        else if (abort)  state_n = S_DONE;
      end
      S_WAIT: begin
        shift_n = mem.mem_data;
        baud_n  = '0;
        state_n = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_n  = '0;
          sent_n  = sent_inc;
          state_n = (sent_inc == len_q || abort) ? S_DONE : S_FETCH;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // tx is registered from the next-state view so the line never glitches between frames.
    tx_n = 1'b1;
    if (state_n == S_START)     tx_n = 1'b0;
    else if (state_n == S_DATA) tx_n = shift_n[0];
  end

  assign mem.mem_req  = (state == S_FETCH);
  assign mem.mem_addr = OBUF + ((off_q + sent) & MASK);
  assign busy         = (state == S_FETCH) || (state == S_WAIT) || (state == S_START) ||
                        (state == S_DATA)  || (state == S_STOP);
  assign done         = (state == S_DONE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_obuf_uart_tx.sv
// Bench for obuf_uart_tx: table of transfers, hand-written abort/reset sequences and random
// transfers, checked by a UART frame decoder against a byte-stream model of the OBUF window.
module tb_obuf_uart_tx;

  localparam int ASZ    = 17;
  localparam int OBUF_I = 'h1400;
  localparam int SZ     = 'h400;
  localparam int CPB    = 3;

  logic           clk;
  logic           rst_n;
  logic           go;
  logic           abort;
  logic [ASZ-1:0] len;
  logic [ASZ-1:0] offset;
  logic           tx;
  logic           busy;
  logic           done;
  logic [ASZ-1:0] sent;
  logic [2:0]     state_dbg;

  obuf_uart_tx_if #(.ASZ(ASZ)) mbus ();

  obuf_uart_tx #(
    .ASZ(ASZ), .OBUF(17'h1400), .OBUF_SZ(17'h400), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .len(len), .offset(offset), .abort(abort),
    .mem(mbus.master), .tx(tx), .busy(busy), .done(done), .sent(sent), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within 90000 cycles");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]     obuf_mem [0:SZ-1];
  logic [7:0]     exp_q[$];
  logic [7:0]     rx_q[$];
  logic [ASZ-1:0] exp_addr_q[$];
  logic [ASZ-1:0] addr_q[$];
  int             cur_n;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int             stall_cycles = 0;
  int             stall_cnt    = 0;
  int             gnt_left     = -1;
  logic           pend         = 1'b0;
  logic [ASZ-1:0] pend_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      mbus.mem_gnt  = 1'b0;
      mbus.mem_data = 8'h00;
      pend          = 1'b0;
      stall_cnt     = 0;
    end else begin
      if (pend) begin
        int a;
        a = int'(pend_addr) - OBUF_I;
        mbus.mem_data = (a >= 0 && a < SZ) ? obuf_mem[a] : 8'($urandom);
        pend = 1'b0;
      end else begin
        mbus.mem_data = 8'($urandom);
      end
      if (mbus.mem_req) begin
        if (gnt_left != 0 && stall_cnt >= stall_cycles) begin
          mbus.mem_gnt = 1'b1;
          pend         = 1'b1;
          pend_addr    = mbus.mem_addr;
          addr_q.push_back(mbus.mem_addr);
          stall_cnt    = 0;
          if (gnt_left > 0) gnt_left--;
        end else begin
          mbus.mem_gnt = 1'b0;
          stall_cnt++;
        end
      end else begin
        mbus.mem_gnt = 1'($urandom);
        stall_cnt    = 0;
      end
    end
  end

  // ---------------- UART frame decoder ----------------
  logic mon_prev = 1'b1;

  always begin : uart_mon
    logic [7:0] b;
    int         bad;
    logic       trunc;
    @(negedge clk);
    if (rst_n && mon_prev && tx === 1'b0) begin
      b = '0; bad = 0; trunc = 1'b0;
      for (int i = 0; i < 10 * CPB; i++) begin
        if (i > 0) @(negedge clk);
        if (!rst_n) begin
          trunc = 1'b1;
          break;
        end
        if (i < CPB) begin
          if (tx !== 1'b0) bad++;
        end else if (i >= 9 * CPB) begin
          if (tx !== 1'b1) bad++;
        end else if ((i % CPB) == 0) begin
          b[i / CPB - 1] = tx;
        end else if (tx !== b[i / CPB - 1]) begin
          bad++;
        end
      end
      if (!trunc) begin
        chk("frame_shape", bad, 0);
        rx_q.push_back(b);
      end
    end
    mon_prev = tx;
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [ASZ-1:0] l, input logic [ASZ-1:0] o,
                            input int stall, input int n_exp, input logic ab);
    rx_q.delete(); addr_q.delete(); exp_q.delete(); exp_addr_q.delete();
    stall_cycles = stall;
    // Reference: character i comes from OBUF + ((offset + i) mod OBUF_SZ).
    for (int i = 0; i < n_exp; i++) begin
      int a;
      a = (int'(o) + i) % SZ;
      exp_q.push_back(obuf_mem[a]);
      exp_addr_q.push_back(ASZ'(OBUF_I + a));
    end
    cur_n = n_exp;
    @(negedge clk);
    go = 1'b1; len = l; offset = o; abort = ab;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    chk("busy_after_go", busy, (l != '0));
    chk("req_after_go", mbus.mem_req, (l != '0));
    chk("done_after_go", done, (l == '0));
  endtask

  task automatic finish_xfer(input string tag);
    int cyc, busy_bad, budget;
    budget   = cur_n * (10 * CPB + 8 + stall_cycles) + 40;
    cyc      = 0;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < budget) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_held"}, busy_bad, 0);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_req_in_done"}, mbus.mem_req, 0);
    chk({tag, "_sent"}, sent, cur_n);
    chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    chk({tag, "_addr_count"}, addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_rx_byte"}, rx_q[i], exp_q[i]);
    for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
      chk({tag, "_addr"}, addr_q[i], exp_addr_q[i]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_tx_idle"}, tx, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ASZ-1:0] len;
    logic [ASZ-1:0] off;
    int             stall;
    int             npre;
    logic [39:0]    pre;
    int             exp_sent;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; len = '0; offset = '0;
    for (int i = 0; i < SZ; i++) obuf_mem[i] = 8'($urandom);

    vecs[0] = '{len: 17'd1,     off: 17'h000,  stall: 0, npre: 1, pre: 40'h00_0000_0041,  exp_sent: 1};
    vecs[1] = '{len: 17'd5,     off: 17'h020,  stall: 3, npre: 5, pre: 40'h0A_3120_6B6F,  exp_sent: 5};
    vecs[2] = '{len: 17'd4,     off: 17'h3FE,  stall: 1, npre: 4, pre: 40'h00_4433_2211,  exp_sent: 4};
    vecs[3] = '{len: 17'd0,     off: 17'h005,  stall: 0, npre: 0, pre: 40'h0,             exp_sent: 0};
    vecs[4] = '{len: 17'h800,   off: 17'h007,  stall: 0, npre: 0, pre: 40'h0,             exp_sent: 'h400};
    vecs[5] = '{len: 17'd2,     off: 17'h1403, stall: 2, npre: 2, pre: 40'h00_0000_5A3C,  exp_sent: 2};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_req", mbus.mem_req, 0);
    chk("rst_addr", mbus.mem_addr, OBUF_I);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent, 0);
    chk("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].npre; i++)
        obuf_mem[(int'(vecs[v].off) + i) % SZ] = vecs[v].pre[8*i +: 8];
      gnt_left = -1;
      start_xfer(vecs[v].len, vecs[v].off, vecs[v].stall, vecs[v].exp_sent, 1'b0);
      finish_xfer("vec");
    end

    // abort during DATA of the third character
    begin
      int cyc;
      start_xfer(17'd10, 17'h000, 0, 3, 1'b0);
      cyc = 0;
      while (rx_q.size() < 2 && cyc < 500) begin @(negedge clk); cyc++; end
      chk("abort_data_two_chars", rx_q.size(), 2);
      repeat (CPB + 3) @(negedge clk);
      abort = 1'b1;
      finish_xfer("abort_data");
      abort = 1'b0;
    end

    // abort while the second fetch is waiting on a withheld grant
    begin
      int cyc;
      gnt_left = 1;
      start_xfer(17'd10, 17'h100, 0, 1, 1'b0);
      cyc = 0;
      while (!(addr_q.size() == 1 && mbus.mem_req === 1'b1) && cyc < 500) begin
        @(negedge clk); cyc++;
      end
      repeat (2) @(negedge clk);
      chk("abort_fetch_req_held", mbus.mem_req, 1);
      abort = 1'b1;
      finish_xfer("abort_fetch");
      abort = 1'b0;
      gnt_left = -1;
    end

    // go and abort together: go wins, abort gone before any check point
    start_xfer(17'd2, 17'h050, 1, 2, 1'b1);
    finish_xfer("go_abort");

    // asynchronous reset in the middle of the second character's data bits
    begin
      int cyc;
      obuf_mem[0] = 8'h41;
      obuf_mem[1] = 8'h41;
      start_xfer(17'd3, 17'h000, 0, 3, 1'b0);
      cyc = 0;
      while (rx_q.size() < 1 && cyc < 500) begin @(negedge clk); cyc++; end
      cyc = 0;
      while (tx !== 1'b0 && cyc < 50) begin @(negedge clk); cyc++; end
      repeat (CPB + 2) @(negedge clk);
      chk("pre_rst_sent", sent, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", tx, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_req", mbus.mem_req, 0);
      chk("async_rst_sent", sent, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_state", state_dbg, 0);
      chk("post_rst_sent", sent, 0);
      chk("post_rst_tx", tx, 1);
    end

    // random transfers against the reference model
    for (int r = 0; r < 6; r++) begin
      logic [ASZ-1:0] l, o;
      int s, n;
      l = ASZ'($urandom_range(1, 5));
      o = ASZ'($urandom_range(0, SZ - 1));
      s = $urandom_range(0, 3);
      n = (int'(l) > SZ) ? SZ : int'(l);
      start_xfer(l, o, s, n, 1'b0);
      finish_xfer("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obuf_uart_tx.md
Name: obuf_uart_tx

Overview:
- Drains eJ32 output characters from the OBUF region of the 8-bit byte memory and transmits them on a UART TX line (8N1, LSB first).
- Masters a single-byte read port on the mb8 memory side, arbitrated with the core by a request/grant handshake.
- Sits beside eJ32. Software or a bench pulses go with the byte count after the core has filled OBUF.

Parameters:
OBUF, 'h1400, base byte address of the output buffer
OBUF_SZ, 'h400, buffer size in bytes (power of 2); reads wrap within OBUF..OBUF+OBUF_SZ-1
ASZ, 17, byte address width (128K space)
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
go  in  1  single-cycle start pulse; sampled only in IDLE
len  in  ASZ  bytes to send, captured on go; values above OBUF_SZ are clamped to OBUF_SZ
offset  in  ASZ  start offset into OBUF, captured on go, taken modulo OBUF_SZ
abort  in  1  level; stop after the character currently on the line
mem_req  out  1  read request to memory arbiter
mem_gnt  in  1  grant; mem_addr is sampled by memory on the cycle req&gnt
mem_addr  out  ASZ  byte read address
mem_data  in  8  read data, valid exactly 1 clk after the req&gnt cycle
tx  out  1  UART serial out, idle high
busy  out  1  high from the cycle after an accepted go until done
done  out  1  single-cycle pulse at end of transfer (normal, abort, or len=0)
sent  out  ASZ  bytes fully transmitted (stop bit completed) in current/last transfer

Behaviour:
- Reset (async, rst_n=0) values: tx=1, mem_req=0, mem_addr=OBUF, busy=0, done=0, sent=0, state=IDLE, baud counter=0, bit index=0. Reset mid-frame truncates the character immediately; tx returns high with no glitch low.
- IDLE:
  - go=1 captures len/offset, clears sent, sets busy next cycle.
  - len=0 → DONE directly (done pulses 1 cycle after go, tx never leaves high).
  - Otherwise → FETCH.
  - go is ignored in every other state.
- FETCH:
  - mem_req=1, mem_addr=OBUF + ((offset+sent) & (OBUF_SZ-1)).
  - Holds until mem_gnt=1, then → WAIT.
  - mem_req drops the cycle after the grant.
  - No request is issued while a character is shifting.
- WAIT: one cycle; → START, latching mem_data into the shift register on that edge.
- START: tx=0 for CLKS_PER_BIT cycles → DATA.
- DATA:
  - Eight bits, shift[0] first, each held CLKS_PER_BIT cycles.
  - Bit index counts 0..7, then → STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle, sent increments.
  - Then → DONE if sent+1==len or abort=1 is sampled; otherwise → FETCH.
- DONE: done=1 for one cycle, busy=0, → IDLE.
- Character period: 10*CLKS_PER_BIT cycles on the line, plus a fetch gap of 2 cycles + grant wait between characters. tx stays high during the gap.
- Address wrap: offset+sent is computed modulo OBUF_SZ. mem_addr never leaves the buffer region.
- abort behaviour:
  - Asserted in FETCH before the grant: drop mem_req, → DONE, no further char; sent unchanged.
  - Asserted in WAIT/START/DATA/STOP: the current char completes, then → DONE.
  - Asserted in IDLE: no effect.
- Simultaneous go and abort in IDLE: go wins and the transfer starts. abort only takes effect if still high at the next check point.
- mem_gnt while mem_req=0 is ignored.

Test Plan:
- Reset: hold rst_n=0 mid-DATA of char 'A' → tx=1, busy=0, mem_req=0 asynchronously; after release, IDLE with sent=0.
- Single char: OBUF[0]='h41, go len=1 offset=0, CLKS_PER_BIT=16 → mem_addr='h1400; tx low 16 clk, then bits 1,0,0,0,0,0,1,0, then high 16; done pulses once; sent=1.
- Multi-char with grant stalls: OBUF holds "ok 1\n", len=5; mem_gnt withheld 3 cycles per request → decoded stream 6F 6B 20 31 0A; tx high throughout the stalls; sent=5.
- Wrap: offset='h3FE, len=4, bytes at 'h17FE,'h17FF,'h1400,'h1401 = 11,22,33,44 → addresses issued in that order; decoded 11 22 33 44.
- Edge counts: len=0 → done 1 cycle after go, no mem_req; len='h800 → clamped, sent ends at 'h400.
- Abort: len=10, raise abort during 3rd char's DATA → 3 chars sent, done, sent=3; abort raised in FETCH with mem_gnt=0 → no further char, mem_req drops.
